// File: rtl/watch_pkg.sv
// Shared constants for the wristwatch time-of-day core: mode encoding, BCD limits,
// reset times and a two-digit BCD increment helper.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    localparam logic [7:0] SEC_MAX      = 8'h59;
    localparam logic [7:0] MIN_MAX      = 8'h59;
    localparam logic [7:0] HR24_MAX     = 8'h23;
    localparam logic [7:0] HR12_MAX     = 8'h12;
    localparam logic [7:0] HR12_PRE_NOON = 8'h11;

    localparam logic [7:0] SEC_RESET    = 8'h00;
    localparam logic [7:0] MIN_RESET    = 8'h00;
    localparam logic [7:0] HR24_RESET   = 8'h00;
    localparam logic [7:0] HR12_RESET   = 8'h12;

    // Units digit rolls 9->0 and carries into tens; callers handle the field limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: clear-to-value, increment, and wrap at max_val.
// wrap flags an increment that rolls the count over, for chaining into the next field.
module bcd_mod_counter
    import watch_pkg::*;
(
    input  logic       clk_27Mhz,
    input  logic       reset,
    input  logic       clr,
    input  logic [7:0] clr_val,
    input  logic       inc,
    input  logic [7:0] max_val,
    output logic [7:0] count,
    output logic       wrap
);

    logic [7:0] count_reg;

    assign count = count_reg;
    assign wrap  = inc && (count_reg == max_val);

    // Clear wins over inc; wrap is still reported so a carry is not lost.
    always_ff @(posedge clk_27Mhz) begin
        if (reset)
            count_reg <= 8'h00;
        else if (clr)
            count_reg <= clr_val;
        else if (inc)
            count_reg <= wrap ? 8'h00 : bcd_inc(count_reg);
    end

endmodule

// File: rtl/watch_timekeeper.sv
// Time-of-day core: synchronizes the 1 Hz input, runs a BCD hh:mm:ss clock and a
// RUN/SET_HR/SET_MIN button state machine. Define WATCH_12HR_EN for 12-hour + pm.
module watch_timekeeper
    import watch_pkg::*;
(
    input  logic       clk_27Mhz,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       sec_pulse,
    output logic       pm
);

    logic  s1_reg, s2_reg, s3_reg;
    logic  mode_lvl_reg, mode_hist_reg;
    logic  inc_lvl_reg, inc_hist_reg;
    mode_t state_reg;
    logic  sec_pulse_reg;
    logic  [7:0] hr_reg;

    logic  tick, mode_edge, inc_edge;
    logic  in_run, in_set_hr, in_set_min;
    logic  sec_wrap, min_wrap, min_inc, hr_inc;

    // Stages reset high so a level already high at release is not counted.
    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            s1_reg        <= 1'b1;
            s2_reg        <= 1'b1;
            s3_reg        <= 1'b1;
            mode_lvl_reg  <= 1'b1;
            mode_hist_reg <= 1'b1;
            inc_lvl_reg   <= 1'b1;
            inc_hist_reg  <= 1'b1;
        end else begin
            s1_reg        <= clk_1hz;
            s2_reg        <= s1_reg;
            s3_reg        <= s2_reg;
            mode_lvl_reg  <= btn_mode;
            mode_hist_reg <= mode_lvl_reg;
            inc_lvl_reg   <= btn_inc;
            inc_hist_reg  <= inc_lvl_reg;
        end
    end

    assign tick      = s2_reg & ~s3_reg;
    assign mode_edge = mode_lvl_reg & ~mode_hist_reg;
    assign inc_edge  = inc_lvl_reg & ~inc_hist_reg;

    assign in_run     = (state_reg == RUN);
    assign in_set_hr  = (state_reg == SET_HR);
    assign in_set_min = (state_reg == SET_MIN);

    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            state_reg     <= RUN;
            sec_pulse_reg <= 1'b0;
        end else begin
            sec_pulse_reg <= tick & in_run;
            case (state_reg)
                RUN:     if (mode_edge) state_reg <= SET_HR;
                SET_HR:  if (mode_edge) state_reg <= SET_MIN;
                SET_MIN: if (mode_edge) state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    // Leaving RUN counts any coincident tick first, then clears seconds.
    bcd_mod_counter u_sec (
        .clk_27Mhz (clk_27Mhz),
        .reset     (reset),
        .clr       (in_run & mode_edge),
        .clr_val   (SEC_RESET),
        .inc       (in_run & tick),
        .max_val   (SEC_MAX),
        .count     (sec_bcd),
        .wrap      (sec_wrap)
    );

    assign min_inc = (in_run & sec_wrap) | (in_set_min & inc_edge);

    bcd_mod_counter u_min (
        .clk_27Mhz (clk_27Mhz),
        .reset     (reset),
        .clr       (1'b0),
        .clr_val   (MIN_RESET),
        .inc       (min_inc),
        .max_val   (MIN_MAX),
        .count     (min_bcd),
        .wrap      (min_wrap)
    );

    // Minute wraps in SET_MIN must not reach hours, hence the RUN gate.
    assign hr_inc = (in_run & min_wrap) | (in_set_hr & inc_edge);

`ifdef WATCH_12HR_EN
    logic pm_reg;

    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            hr_reg <= HR12_RESET;
            pm_reg <= 1'b0;
        end else if (hr_inc) begin
            if (hr_reg == HR12_MAX) begin
                hr_reg <= 8'h01;
            end else begin
                hr_reg <= bcd_inc(hr_reg);
                if (hr_reg == HR12_PRE_NOON)
                    pm_reg <= ~pm_reg;
            end
        end
    end

    assign pm = pm_reg;
`else
    always_ff @(posedge clk_27Mhz) begin
        if (reset)
            hr_reg <= HR24_RESET;
        else if (hr_inc)
            hr_reg <= (hr_reg == HR24_MAX) ? 8'h00 : bcd_inc(hr_reg);
    end

    assign pm = 1'b0;
`endif

    assign hr_bcd    = hr_reg;
    assign mode      = state_reg;
    assign sec_pulse = sec_pulse_reg;

endmodule

// File: doc/watch_timekeeper.md
# watch_timekeeper

Time-of-day core of the wristwatch: consumes the divided 1 Hz clock from the clock divider, synchronizes and edge-detects it in the 27 MHz domain, and advances a BCD hours:minutes:seconds count. Two externally debounced buttons provide a mode/set state machine for adjusting hours and minutes. Outputs feed the display driver directly.

## Interface
- No parameters; all limits are fixed constants in the shared package.
- clk_27Mhz  input  1  user clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high
- clk_1hz  input  1  divided clock from the divider; treated as an asynchronous level
- btn_mode  input  1  debounced level; a rising edge advances the mode
- btn_inc  input  1  debounced level; a rising edge increments the field being set
- hr_bcd  output  8  hours as two BCD digits, [7:4] tens and [3:0] units
- min_bcd  output  8  minutes as BCD
- sec_bcd  output  8  seconds as BCD
- mode  output  2  0 RUN, 1 SET_HR, 2 SET_MIN
- sec_pulse  output  1  single-cycle strobe for each counted second
- pm  output  1  PM flag; constant 0 unless 12-hour mode is compiled in

## Operation
- **Synchronizer:** clk_1hz passes through s1→s2→s3. A tick is `s2 & ~s3`. Reset loads all three stages to 1, so the first counted tick is the first 0→1 transition of clk_1hz that completes after reset is released.
- **Button edges:** btn_mode and btn_inc each have a one-flop history register, reset to 1. An edge is `level & ~hist`.
- **FSM states:** RUN, SET_HR, SET_MIN.
  - RUN →(mode edge) SET_HR →(mode edge) SET_MIN →(mode edge) RUN.
  - Encoding 3 is unreachable; if it occurs, the next cycle goes to RUN.
- **RUN:**
  - Each tick increments seconds.
  - 59 s wraps to 00 and carries into minutes; 59 min wraps to 00 and carries into hours.
  - 24-hour mode: 23:59:59 → 00:00:00.
  - sec_pulse asserts for one cycle on every tick counted in RUN.
  - inc edges are ignored.
- **SET_HR:**
  - Entering SET_HR clears seconds to 00.
  - Ticks are ignored; seconds stay frozen at 00 and sec_pulse stays 0.
  - Each inc edge increments hours, wrapping 23→00, with no carry to any other field.
- **SET_MIN:**
  - Ticks are ignored.
  - Each inc edge increments minutes, wrapping 59→00, with no carry into hours.
- **Simultaneous events:**
  - When a tick, inc edge and mode edge fall in the same cycle, the tick and inc are applied according to the current (pre-transition) state, and the mode change takes effect on the same edge.
  - So a mode edge from RUN on a tick cycle counts that second, then clears seconds on entry to SET_HR.
- **Counter representation:** counters are stored as BCD. The units digit wraps 9→0 with a carry into the tens digit. Non-BCD values never occur from reset.
- **Reset values (reset mid-operation included):**
  - All outputs return to their reset values on the next edge.
  - 24-hour mode: hr_bcd=8'h00, min_bcd=8'h00, sec_bcd=8'h00.
  - mode=0, sec_pulse=0, pm=0.

## Timing
- A clk_1hz rise first sampled high at edge N is reflected in sec_bcd, and sec_pulse asserts, after edge N+2. Latency is 3 clock edges; sec_pulse is high for exactly the cycle following edge N+2.
- A button rise sampled at edge N changes mode or the set field after edge N+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum clk_1hz high and low time is 2 clk_27Mhz cycles. Shorter pulses may be missed.

## Configuration
- **WATCH_12HR_EN defined:**
  - Hours count 12, 01 … 11, then back to 12.
  - Reset value is 12:00:00 with pm=0.
  - In RUN, 11:59:59 → 12:00:00 toggles pm; 12:59:59 → 01:00:00 leaves pm unchanged.
  - In SET_HR, an inc edge at 11 goes to 12 and toggles pm; an inc edge at 12 goes to 01.
- **Undefined:** 24-hour behaviour as described above; pm is tied to 0.

## Structure
- **Package watch_pkg:**
  - mode state encoding constants (RUN, SET_HR, SET_MIN);
  - BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23, HR12_MAX=8'h12;
  - reset time constants.
- **Sub-module bcd_mod_counter:**
  - two-digit BCD counter with a synchronous clear, a load value, an inc input and a max compare;
  - outputs the count and a wrap/carry signal;
  - instantiated for seconds and minutes.
- Hours logic, including the 12-hour variant, is written inline.

## Test plan
- **Reset:** reset with clk_1hz high, then release with clk_1hz held high for 100 cycles → no sec_pulse and sec_bcd=8'h00. The next 0→1 transition gives sec_bcd=8'h01 exactly 3 edges after it is first sampled.
- **Full rollover:** preload by setting 23:59 via the buttons, return to RUN, then apply 60 ticks → 00:00:00. Check the intermediate value 23:59:59 and that sec_pulse appears once per tick.
- **Set mode:** mode edge from RUN at 10:20:33 → SET_HR with sec_bcd=8'h00. 14 inc edges → hr_bcd=8'h00 (wrap from 23, minutes unchanged). Mode edge → SET_MIN; ticks ignored for 5 s.
- **Same-cycle events:** mode edge and tick in the same cycle at 10:20:33 → sec_bcd becomes 8'h00 and mode=1. sec_pulse asserts once.
- **Reset mid-set:** assert reset while in SET_MIN with min_bcd=8'h45 → next cycle mode=0, all BCD outputs 8'h00.
- **WATCH_12HR_EN:**
  - 11:59:59 pm=0 plus one tick → 12:00:00 pm=1.
  - 12:59:59 plus one tick → 01:00:00 pm=1.
  - SET_HR at 12 plus one inc → 01.
